pal_timing_detect: RTL
======================

PAL_TIMING_DETECT -- requirements
Module: pal_timing_detect

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 114000000, frequency of clk used to derive all rate thresholds.
REQ-002 SHALL have parameter STABLE_FRAMES, default 4, consecutive matching frames required before the reported mode changes (range 1..15).
REQ-003 SHALL have parameter VGA_LINES, default 400, line count above which input is classed as VGA.
REQ-004 SHALL have ports:
  - clk  in  1  sole clock.
  - reset  in  1  synchronous, active-low reset.
  - i_hsync  in  1  raw PAL/VGA hsync, asynchronous.
  - i_vsync  in  1  raw vsync, asynchronous.
  - o_lines  out  11  hsync pulses in last complete frame.
  - o_frame_clks  out  24  clk cycles in last complete frame.
  - o_frame_strobe  out  1  one-cycle pulse when o_lines/o_frame_clks update.
  - o_valid  out  1  mode locked.
  - o_50hz  out  1  locked at 50 Hz class.
  - o_60hz  out  1  locked at 60 Hz class.
  - o_vga  out  1  locked and line count > VGA_LINES.
  - o_no_signal  out  1  no vsync for TIMEOUT cycles.

Function
REQ-005 SHALL pass i_hsync and i_vsync through 2-flop synchronizers; edges SHALL be detected on a third registered stage.
REQ-006 SHALL define a frame boundary as the leading edge of the vsync pulse (rising edge when active-high) and a line as the leading edge of the hsync pulse.
REQ-007 SHALL count clk cycles in a 24-bit frame counter, saturating at 2^24-1, and hsync edges in an 11-bit line counter, saturating at 2047.
REQ-008 SHALL, on a frame boundary detected in cycle N, register both counts into o_frame_clks/o_lines and pulse o_frame_strobe in cycle N+1, then restart counting from 1 clock and 0 lines.
REQ-009 An hsync edge coincident with a vsync edge SHALL count into the new frame.
REQ-010 SHALL classify each completed frame with period P:
  - 50 Hz if CLK_FREQ_HZ/55 <= P <= CLK_FREQ_HZ/45.
  - 60 Hz if CLK_FREQ_HZ/65 <= P < CLK_FREQ_HZ/55.
  - otherwise OUT_OF_RANGE.
  - Thresholds SHALL be elaboration-time constants; no runtime divider.
REQ-011 SHALL implement states NO_SIGNAL, ACQUIRE, MEASURE, LOCKED:
  - NO_SIGNAL -> ACQUIRE on first vsync edge; this edge only starts counting and produces no strobe.
  - ACQUIRE -> MEASURE on the next edge (first complete frame).
  - MEASURE -> LOCKED when STABLE_FRAMES consecutive frames share one non-OUT_OF_RANGE class and the same VGA decision.
  - LOCKED -> LOCKED with the new mode when STABLE_FRAMES consecutive frames agree on a different valid class.
  - Any state -> NO_SIGNAL when the frame counter reaches TIMEOUT = CLK_FREQ_HZ/20.
REQ-012 SHALL use a 4-bit match counter:
  - Set to 1 when the frame class differs from the previous frame's class; otherwise incremented, saturating at 15.
  - In LOCKED, fewer than STABLE_FRAMES deviating or OUT_OF_RANGE frames SHALL NOT alter any mode output.
REQ-013 Mode outputs SHALL update in the same cycle as o_frame_strobe (N+1).
REQ-014 o_50hz and o_60hz SHALL be mutually exclusive; both SHALL be 0 whenever o_valid is 0.
REQ-015 On entering NO_SIGNAL:
  - o_valid, o_50hz, o_60hz and o_vga SHALL clear in the following cycle and o_no_signal SHALL set.
  - o_lines and o_frame_clks SHALL hold their last values.
  - o_no_signal SHALL clear on the next vsync edge.

Reset
REQ-016 While reset is low at a clk edge, all counters, synchronizers and registered outputs SHALL clear to 0, except o_no_signal which SHALL be 1, and the state SHALL become NO_SIGNAL.
REQ-017 Reset asserted mid-frame SHALL discard the partial frame; the first vsync edge after release SHALL behave as in NO_SIGNAL.

Configuration
REQ-018 With macro PAL_TIMING_POLARITY_DETECT_EN defined, the block SHALL auto-detect polarity of each sync independently:
  - Measure high and low durations between consecutive rising edges; the shorter phase is the active pulse.
  - The leading edge SHALL follow the detected polarity from the next period.
  - Polarity SHALL reset to active-high.
REQ-019 Without PAL_TIMING_POLARITY_DETECT_EN, both syncs SHALL be treated as active-high and no polarity logic SHALL be synthesized.

Verification (CLK_FREQ_HZ=1000000, STABLE_FRAMES=4)
REQ-020 6 frames of 20000 clks, 312 lines -> first strobe o_lines=312, o_frame_clks=20000; o_valid=o_50hz=1, o_vga=0 after the 4th complete frame.
REQ-021 Lock at 50 Hz, then 3 frames of 16667 clks, then 50 Hz again -> o_50hz stays 1 throughout; 4 frames at 16667 -> o_60hz=1, o_50hz=0 at 4th strobe.
REQ-022 Frames of 16667 clks with 525 lines -> o_60hz=1, o_vga=1; o_lines=525.
REQ-023 vsync stopped while locked -> o_valid=0, o_no_signal=1 exactly 50001 cycles after the last edge; o_lines unchanged.
REQ-024 Frames of 30000 clks -> never locks, o_valid=0, strobes still issued with o_frame_clks=30000.
REQ-025 Reset low mid-frame for 1 cycle -> all outputs at reset values next cycle; next vsync edge gives no strobe.

Source files
------------

// File: rtl/pal_timing_detect.sv
// pal_timing_detect: measures the frame period and line count of a raw PAL/VGA
// sync pair and reports a debounced video mode (50 Hz / 60 Hz, VGA or not).
// Optional build macro PAL_TIMING_POLARITY_DETECT_EN adds per-sync polarity
// auto-detection; without it both syncs are taken as active-high.
module pal_timing_detect #(
  parameter int unsigned CLK_FREQ_HZ   = 114000000,
  parameter int unsigned STABLE_FRAMES = 4,
  parameter int unsigned VGA_LINES     = 400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_hsync,
  input  logic        i_vsync,
  output logic [10:0] o_lines,
  output logic [23:0] o_frame_clks,
  output logic        o_frame_strobe,
  output logic        o_valid,
  output logic        o_50hz,
  output logic        o_60hz,
  output logic        o_vga,
  output logic        o_no_signal
);

  // Period thresholds are fixed at elaboration, so no divider is built.
  localparam logic [23:0] P50_MIN  = 24'(CLK_FREQ_HZ / 55);
  localparam logic [23:0] P50_MAX  = 24'(CLK_FREQ_HZ / 45);
  localparam logic [23:0] P60_MIN  = 24'(CLK_FREQ_HZ / 65);
  localparam logic [23:0] TIMEOUT  = 24'(CLK_FREQ_HZ / 20);
  localparam logic [3:0]  STABLE_N = 4'(STABLE_FRAMES);
  localparam logic [10:0] VGA_N    = 11'(VGA_LINES);

  localparam logic [1:0] CLS_OOR = 2'd0;
  localparam logic [1:0] CLS_50  = 2'd1;
  localparam logic [1:0] CLS_60  = 2'd2;

  typedef enum logic [1:0] {S_NO_SIGNAL, S_ACQUIRE, S_MEASURE, S_LOCKED} state_t;

  // Bit 0 carries hsync, bit 1 carries vsync through the synchronizer chain.
  logic [1:0]  sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
  logic [1:0]  lead;
  logic        hs_edge, vs_edge;
  logic [23:0] frame_cnt_q, frame_cnt_d;
  logic [10:0] line_cnt_q, line_cnt_d;
  logic [3:0]  match_q, match_d;
  logic [2:0]  prev_key_q, prev_key_d;
  state_t      state_q, state_d;
  logic [1:0]  frame_cls;
  logic        frame_vga, timeout, measure_edge, stable_hit;
  logic [10:0] lines_q, lines_d;
  logic [23:0] clks_q, clks_d;
  logic        strobe_q, strobe_d, valid_q, valid_d, f50_q, f50_d;
  logic        f60_q, f60_d, vga_q, vga_d, no_sig_q, no_sig_d;

`ifdef PAL_TIMING_POLARITY_DETECT_EN
  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_pol
    logic        pol_low_q, pol_low_d, seen_q, seen_d;
    logic [23:0] hi_q, hi_d, lo_q, lo_d;
    logic        rise;
    assign rise = sync2_q[gi] & ~sync3_q[gi];
    // Time both phases between rising edges; the longer high phase means active-low.
    always_comb begin
      pol_low_d = pol_low_q;
      seen_d    = seen_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      if (rise) begin
        if (seen_q) pol_low_d = (hi_q > lo_q);
        seen_d = 1'b1;
        hi_d   = 24'd1;
        lo_d   = '0;
      end else if (sync2_q[gi]) begin
        if (hi_q != '1) hi_d = hi_q + 24'd1;
      end else begin
        if (lo_q != '1) lo_d = lo_q + 24'd1;
      end
    end
    // Polarity state registers; active-high after reset.
    always_ff @(posedge clk) begin
      if (!reset) begin
        pol_low_q <= 1'b0;
        seen_q    <= 1'b0;
        hi_q      <= '0;
        lo_q      <= '0;
      end else begin
        pol_low_q <= pol_low_d;
        seen_q    <= seen_d;
        hi_q      <= hi_d;
        lo_q      <= lo_d;
      end
    end
    assign lead[gi] = pol_low_q ? (~sync2_q[gi] & sync3_q[gi]) : rise;
  end
`else
  assign lead = sync2_q & ~sync3_q;
`endif

  assign hs_edge = lead[0];
  assign vs_edge = lead[1];

  // Synchronizer shift and frame/line counting; an hsync on the vsync edge opens the new frame.
  always_comb begin
    sync1_d     = {i_vsync, i_hsync};
    sync2_d     = sync1_q;
    sync3_d     = sync2_q;
    frame_cnt_d = frame_cnt_q;
    line_cnt_d  = line_cnt_q;
    if (vs_edge) begin
      frame_cnt_d = 24'd1;
      line_cnt_d  = hs_edge ? 11'd1 : 11'd0;
    end else begin
      if (frame_cnt_q != '1) frame_cnt_d = frame_cnt_q + 24'd1;
      if (hs_edge && line_cnt_q != '1) line_cnt_d = line_cnt_q + 11'd1;
    end
  end

  // Classify the frame that closes on this vsync edge.
  always_comb begin
    frame_cls = CLS_OOR;
    if (frame_cnt_q >= P50_MIN && frame_cnt_q <= P50_MAX)     frame_cls = CLS_50;
    else if (frame_cnt_q >= P60_MIN && frame_cnt_q < P50_MIN) frame_cls = CLS_60;
  end

  assign frame_vga    = (line_cnt_q > VGA_N);
  assign timeout      = (state_q != S_NO_SIGNAL) && (frame_cnt_q >= TIMEOUT);
  assign measure_edge = vs_edge && (state_q != S_NO_SIGNAL) && !timeout;

  // Count consecutive frames sharing the same class and VGA decision.
  always_comb begin
    match_d    = match_q;
    prev_key_d = prev_key_q;
    if (measure_edge) begin
      prev_key_d = {frame_cls, frame_vga};
      if (state_q == S_ACQUIRE || {frame_cls, frame_vga} != prev_key_q) match_d = 4'd1;
      else if (match_q != 4'hF) match_d = match_q + 4'd1;
    end
  end

  assign stable_hit = measure_edge && (match_d >= STABLE_N) && (frame_cls != CLS_OOR);

  // Next-state logic; loss of vsync overrides everything.
  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = S_NO_SIGNAL;
    end else if (vs_edge) begin
      case (state_q)
        S_NO_SIGNAL: state_d = S_ACQUIRE;
        S_ACQUIRE,
        S_MEASURE:   state_d = stable_hit ? S_LOCKED : S_MEASURE;
        default:     state_d = S_LOCKED;
      endcase
    end
  end

  // Output logic; mode bits only move on a stable run of valid frames or on loss of signal.
  always_comb begin
    lines_d  = lines_q;
    clks_d   = clks_q;
    strobe_d = measure_edge;
    valid_d  = valid_q;
    f50_d    = f50_q;
    f60_d    = f60_q;
    vga_d    = vga_q;
    no_sig_d = no_sig_q;
    if (timeout) begin
      valid_d  = 1'b0;
      f50_d    = 1'b0;
      f60_d    = 1'b0;
      vga_d    = 1'b0;
      no_sig_d = 1'b1;
    end else begin
      if (vs_edge && state_q == S_NO_SIGNAL) no_sig_d = 1'b0;
      if (measure_edge) begin
        lines_d = line_cnt_q;
        clks_d  = frame_cnt_q;
      end
      if (stable_hit) begin
        valid_d = 1'b1;
        f50_d   = (frame_cls == CLS_50);
        f60_d   = (frame_cls == CLS_60);
        vga_d   = frame_vga;
      end
    end
  end

  // All registers, cleared by the synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      sync3_q     <= '0;
      frame_cnt_q <= '0;
      line_cnt_q  <= '0;
      match_q     <= '0;
      prev_key_q  <= '0;
      state_q     <= S_NO_SIGNAL;
      lines_q     <= '0;
      clks_q      <= '0;
      strobe_q    <= 1'b0;
      valid_q     <= 1'b0;
      f50_q       <= 1'b0;
      f60_q       <= 1'b0;
      vga_q       <= 1'b0;
      no_sig_q    <= 1'b1;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      sync3_q     <= sync3_d;
      frame_cnt_q <= frame_cnt_d;
      line_cnt_q  <= line_cnt_d;
      match_q     <= match_d;
      prev_key_q  <= prev_key_d;
      state_q     <= state_d;
      lines_q     <= lines_d;
      clks_q      <= clks_d;
      strobe_q    <= strobe_d;
      valid_q     <= valid_d;
      f50_q       <= f50_d;
      f60_q       <= f60_d;
      vga_q       <= vga_d;
      no_sig_q    <= no_sig_d;
    end
  end

  assign o_lines        = lines_q;
  assign o_frame_clks   = clks_q;
  assign o_frame_strobe = strobe_q;
  assign o_valid        = valid_q;
  assign o_50hz         = f50_q;
  assign o_60hz         = f60_q;
  assign o_vga          = vga_q;
  assign o_no_signal    = no_sig_q;

endmodule
